// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Holds the controller state enum and the add/sub mode encodings.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit combinational full adder used as the single arithmetic cell.
// Ports: a, b, cin (inputs); s (sum), cout (carry out).
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: resolves one bit per clock through one
// full-adder cell with a registered carry, then pulses done.
// Ports: clk, reset (async, active-high); start, sub, cin, a, b (request);
//        busy, done, sum, cout, ovf (registered results and status).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_shift;

    // Operand registers shift right, so bit 0 is always the live bit.
    full_adder_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 is at sum[0].
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_shift = fa_s;
        end else begin : g_wn
            assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = (sub == MODE_SUB) ? ~b : b;
                    carry_d = (sub == MODE_SUB) ? 1'b1 : cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                sum_d   = sum_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = fa_co;
                    // carry_q here is the carry into the MSB
                    ovf_d   = carry_q ^ fa_co;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
// Expected results come from integer arithmetic on the operands.
module tb_serial_adder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       st8, sub8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic       st1, sub1, cin1, busy1, done1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .start(st1), .sub(sub1), .cin(cin1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1),
        .cout(cout1), .ovf(ovf1)
    );

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    int   dones8 = 0;
    int   dones1 = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: unsigned result and carry from plain integer sums; signed
    // overflow as "true signed result does not fit in w bits".
    function automatic exp_t model(int w, bit s, bit c,
                                   logic [63:0] a, logic [63:0] b);
        exp_t   e;
        longint mask, ua, ub, sa, sb, r, sr, smax, smin;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = ((ua >> (w - 1)) & 1) != 0 ? ua - (longint'(1) << w) : ua;
        sb   = ((ub >> (w - 1)) & 1) != 0 ? ub - (longint'(1) << w) : ub;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        if (s) begin
            r      = ua - ub;
            e.cout = (ua >= ub);
            sr     = sa - sb;
        end else begin
            r      = ua + ub + longint'(c);
            e.cout = ((r >> w) & 1) != 0;
            sr     = sa + sb + longint'(c);
        end
        e.sum = 64'(r & mask);
        e.ovf = (sr > smax) || (sr < smin);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            dones8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done8_unexpected: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("sum8", 64'(sum8), e.sum);
                chk("cout8", 64'(cout8), 64'(e.cout));
                chk("ovf8", 64'(ovf8), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            dones1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done1_unexpected: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("sum1", 64'(sum1), e.sum);
                chk("cout1", 64'(cout1), 64'(e.cout));
                chk("ovf1", 64'(ovf1), 64'(e.ovf));
            end
        end
    end

    // Issues a start at a negedge; returns at the first RUN-cycle negedge
    // with the inputs scrambled to prove they are not re-sampled.
    task automatic start8(logic [7:0] a, logic [7:0] b, bit c, bit s, bit push);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; sub8 = s; st8 = 1'b1;
        if (push) q8.push_back(model(8, s, c, 64'(a), 64'(b)));
        @(negedge clk);
        st8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); sub8 = 1'($urandom);
    endtask

    task automatic start1(bit a, bit b, bit c, bit s);
        @(negedge clk);
        a1 = a; b1 = b; cin1 = c; sub1 = s; st1 = 1'b1;
        q1.push_back(model(1, s, c, 64'(a), 64'(b)));
        @(negedge clk);
        st1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom);
        cin1 = 1'($urandom); sub1 = 1'($urandom);
    endtask

    task automatic run8(logic [7:0] a, logic [7:0] b, bit c, bit s);
        int lat = 0;
        int bc  = 0;
        start8(a, b, c, s, 1'b1);
        while (done8 !== 1'b1 && lat < 30) begin
            if (busy8) bc++;
            @(negedge clk);
            lat++;
        end
        if (busy8) bc++;
        chk("lat8", 64'(lat), 64'd8);
        chk("busy8_cycles", 64'(bc), 64'd9);
        @(negedge clk);
        chk("idle8", 64'(busy8), 64'd0);
    endtask

    task automatic run1(bit a, bit b, bit c, bit s);
        int lat = 0;
        start1(a, b, c, s);
        while (done1 !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk("lat1", 64'(lat), 64'd1);
        @(negedge clk);
        chk("idle1", 64'(busy1), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;
        logic [7:0] hold;
        reset = 1'b0;
        st8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        st1 = 0; sub1 = 0; cin1 = 0; a1 = 0; b1 = 0;
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_sum8", 64'(sum8), 64'd0);
        chk("rst_cout8", 64'(cout8), 64'd0);
        chk("rst_ovf8", 64'(ovf8), 64'd0);
        chk("rst_busy1", 64'(busy1), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run8(8'h5A, 8'h3C, 1'b0, 1'b0);
        run8(8'hFF, 8'h01, 1'b1, 1'b0);
        run8(8'h10, 8'h20, 1'b1, 1'b1);
        run8(8'h80, 8'h01, 1'b1, 1'b1);

        // Starts while busy and during DONE must be dropped.
        d0 = dones8;
        start8(8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h11; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        a8 = 8'hC3; b8 = 8'h5F; sub8 = 1'b1; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        chk("rej_idle", 64'(busy8), 64'd0);
        chk("rej_sum", 64'(sum8), 64'h77);
        hold = sum8;
        repeat (12) @(negedge clk);
        chk("rej_dones", 64'(dones8 - d0), 64'd1);
        chk("rej_hold", 64'(sum8), 64'(hold));
        chk("rej_idle2", 64'(busy8), 64'd0);

        // Asynchronous reset during RUN.
        start8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", 64'(busy8), 64'd0);
        chk("mid_done", 64'(done8), 64'd0);
        chk("mid_sum", 64'(sum8), 64'd0);
        chk("mid_cout", 64'(cout8), 64'd0);
        chk("mid_ovf", 64'(ovf8), 64'd0);
        q8.delete();
        @(negedge clk);
        reset = 1'b0;
        d0 = dones8;
        repeat (12) @(negedge clk);
        chk("mid_nodone", 64'(dones8 - d0), 64'd0);
        run8(8'h01, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 8; i++) begin
            run1(bit'(i >> 2), bit'(i >> 1), bit'(i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            run1(bit'(i >> 1), bit'(i), 1'b1, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            run1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        chk("q8_empty", 64'(q8.size()), 64'd0);
        chk("q1_empty", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
